// File: rtl/pb_event_arbiter.sv
// pb_event_arbiter
// Synchronizes N raw push-button inputs, detects rising edges and latches each
// one as a pending event. A round-robin arbiter offers one pending event at a
// time to a single consumer over a registered valid/ready channel. Presses that
// land on a channel that is still pending are dropped and counted in a
// saturating overrun counter.
// Optional build macro: PB_DEBOUNCE_EN adds a per-channel stable-count filter
// (DB_CNT cycles) between the synchronizer and the edge detector.
module pb_event_arbiter #(
    parameter int N      = 4,
    parameter int ID_W   = $clog2(N),
    parameter int CNT_W  = 8,
    parameter int DB_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     pb,
    output logic             evt_vld,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_rdy,
    output logic [N-1:0]     pend,
    output logic [CNT_W-1:0] ovr_cnt,
    input  logic             ovr_clr
);

    localparam int PC_W  = $clog2(N + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [SUM_W-1:0] SAT_MAX  = SUM_W'({CNT_W{1'b1}});
    localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]  RR_INIT  = ID_W'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Number of set bits in a channel vector (number of simultaneous drops).
    function automatic logic [PC_W-1:0] popcount(input logic [N-1:0] v);
        logic [PC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc = acc + PC_W'(v[i]);
        end
        return acc;
    endfunction

    // First requesting channel scanning upward from last+1, wrapping modulo N.
    // Distance 0 is the channel right after the last grant, N-1 is the last grant itself.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] req,
                                                input logic [ID_W-1:0] last);
        logic [ID_W-1:0] pick;
        int              best_d;
        int              d;
        pick   = '0;
        best_d = N;
        for (int i = 0; i < N; i++) begin
            d = (i + N - 1 - int'(last)) % N;
            if (req[i] && (d < best_d)) begin
                best_d = d;
                pick   = ID_W'(i);
            end
        end
        return pick;
    endfunction

    logic [N-1:0]      s1_r;
    logic [N-1:0]      s2_r;
    logic [N-1:0]      h_r;
    logic [N-1:0]      lvl_s;
    logic [N-1:0]      rise_s;
    logic [N-1:0]      consume_s;
    logic [N-1:0]      drop_s;
    logic [N-1:0]      pend_r;
    logic [CNT_W-1:0]  ovr_cnt_r;
    logic [SUM_W-1:0]  ovr_sum_s;
    logic              hs_s;
    logic              evt_vld_r;
    logic [ID_W-1:0]   evt_id_r;
    logic [ID_W-1:0]   rr_r;
    state_t            state_r;

`ifdef PB_DEBOUNCE_EN
    localparam int DB_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

    logic [DB_W-1:0] db_cnt_r [N];
    logic [N-1:0]    f_r;

    // Debounce filter: f adopts s2 only after DB_CNT consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_r <= '0;
            for (int i = 0; i < N; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s2_r[i] == f_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_W'(DB_CNT - 1)) begin
                    f_r[i]      <= s2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1'b1);
                end
            end
        end
    end

    assign lvl_s = f_r;
`else
    assign lvl_s = s2_r;
`endif

    // Two-flop synchronizer and edge-detect history (history tracks the level fed to the detector).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= '0;
            s2_r <= '0;
            h_r  <= '0;
        end else begin
            s1_r <= pb;
            s2_r <= s1_r;
            h_r  <= lvl_s;
        end
    end

    // Per-cycle event classification: new rises, the channel being consumed, and dropped rises.
    always_comb begin
        hs_s      = evt_vld_r & evt_rdy;
        rise_s    = lvl_s & ~h_r;
        consume_s = hs_s ? (ONE_HOT0 << evt_id_r) : '0;
        drop_s    = rise_s & pend_r & ~consume_s;
        ovr_sum_s = SUM_W'(ovr_cnt_r) + SUM_W'(popcount(drop_s));
    end

    // Pending bitmap and saturating overrun counter; a rise coinciding with its own consume re-arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r    <= '0;
            ovr_cnt_r <= '0;
        end else begin
            pend_r <= (pend_r & ~consume_s) | rise_s;
            if (ovr_clr) begin
                ovr_cnt_r <= '0;
            end else if (ovr_sum_s > SAT_MAX) begin
                ovr_cnt_r <= SAT_MAX[CNT_W-1:0];
            end else begin
                ovr_cnt_r <= ovr_sum_s[CNT_W-1:0];
            end
        end
    end

    // Offer FSM: pick round-robin in IDLE, hold the offer until handshake, then one bubble cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            evt_vld_r <= 1'b0;
            evt_id_r  <= '0;
            rr_r      <= RR_INIT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|pend_r) begin
                        evt_id_r  <= rr_pick(pend_r, rr_r);
                        evt_vld_r <= 1'b1;
                        state_r   <= ST_OFFER;
                    end else begin
                        evt_vld_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_OFFER: begin
                    if (hs_s) begin
                        evt_vld_r <= 1'b0;
                        rr_r      <= evt_id_r;
                        state_r   <= ST_IDLE;
                    end else begin
                        evt_vld_r <= 1'b1;
                        state_r   <= ST_OFFER;
                    end
                end
                default: begin
                    evt_vld_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt_vld = evt_vld_r;
    assign evt_id  = evt_id_r;
    assign pend    = pend_r;
    assign ovr_cnt = ovr_cnt_r;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Testbench for pb_event_arbiter: directed scenarios followed by randomized
// button/ready/clear/reset traffic. A cycle-level behavioural model (arrays of
// sampled levels, pending flags, an offered-channel integer) predicts the state
// after every clock edge and every handshake; a negedge monitor pops and compares.
module tb_pb_event_arbiter;

    localparam int N       = 4;
    localparam int ID_W    = $clog2(N);
    localparam int CNT_W   = 3;
    localparam int OVR_MAX = (1 << CNT_W) - 1;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic [N-1:0]     pb      = '0;
    logic             evt_rdy = 1'b0;
    logic             ovr_clr = 1'b0;
    logic             evt_vld;
    logic [ID_W-1:0]  evt_id;
    logic [N-1:0]     pend;
    logic [CNT_W-1:0] ovr_cnt;

    pb_event_arbiter #(
        .N      (N),
        .CNT_W  (CNT_W),
        .DB_CNT (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pb      (pb),
        .evt_vld (evt_vld),
        .evt_id  (evt_id),
        .evt_rdy (evt_rdy),
        .pend    (pend),
        .ovr_cnt (ovr_cnt),
        .ovr_clr (ovr_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           vld;
        int           id;
        logic [N-1:0] pend;
        int           ovr;
    } status_t;

    status_t exp_st_q[$];
    int      exp_hs_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    // Reference model state: levels sampled 1, 2 and 3 edges ago, pending flags,
    // currently offered channel, last granted channel, overrun count.
    bit m_hist[N][3];
    bit m_pend[N];
    bit m_vld = 1'b0;
    int m_id  = 0;
    int m_rr  = N - 1;
    int m_ovr = 0;

    // Advance the model across one clock edge with the inputs held during the preceding cycle.
    task automatic model_step(input logic [N-1:0] p, input bit rdy, input bit clr, input bit rs);
        bit rise[N];
        bit hs;
        int drops;
        int best;
        int c;
        if (rs) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                for (int j = 0; j < 3; j++) m_hist[i][j] = 1'b0;
            end
            m_vld = 1'b0;
            m_id  = 0;
            m_rr  = N - 1;
            m_ovr = 0;
            return;
        end
        hs    = m_vld && rdy;
        drops = 0;
        for (int i = 0; i < N; i++) begin
            rise[i] = m_hist[i][1] && !m_hist[i][2];
            if (rise[i] && m_pend[i] && !(hs && m_id == i)) drops++;
        end
        if (m_vld) begin
            if (hs) begin
                m_rr  = m_id;
                m_vld = 1'b0;
            end
        end else begin
            best = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_rr + k) % N;
                if (best < 0 && m_pend[c]) best = c;
            end
            if (best >= 0) begin
                m_id  = best;
                m_vld = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (hs && m_id == i) m_pend[i] = 1'b0;
            if (rise[i]) m_pend[i] = 1'b1;
        end
        if (clr) m_ovr = 0;
        else     m_ovr = (m_ovr + drops > OVR_MAX) ? OVR_MAX : m_ovr + drops;
        for (int i = 0; i < N; i++) begin
            m_hist[i][2] = m_hist[i][1];
            m_hist[i][1] = m_hist[i][0];
            m_hist[i][0] = p[i];
        end
    endtask

    // Apply one cycle of inputs, record any expected handshake, step the model, queue the expected state.
    task automatic drive(input logic [N-1:0] p, input bit rdy, input bit clr, input bit rs);
        status_t s;
        pb      = p;
        evt_rdy = rdy;
        ovr_clr = clr;
        rst     = rs;
        if (!rs && m_vld && rdy) exp_hs_q.push_back(m_id);
        @(posedge clk);
        model_step(p, rdy, clr, rs);
        s.vld  = m_vld;
        s.id   = m_id;
        s.ovr  = m_ovr;
        s.pend = '0;
        for (int i = 0; i < N; i++) s.pend[i] = m_pend[i];
        exp_st_q.push_back(s);
        #2;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitor: compare the post-edge state every cycle and every handshake the DUT presents.
    always @(negedge clk) begin
        status_t e;
        int      want;
        if (exp_st_q.size() > 0) begin
            e = exp_st_q.pop_front();
            n_tests++;
            if (evt_vld !== e.vld || pend !== e.pend || ovr_cnt !== CNT_W'(e.ovr) ||
                (e.vld && evt_id !== ID_W'(e.id))) begin
                n_fail++;
                $display("FAIL state @%0t: got vld=%0b id=%0d pend=%b ovr=%0d, want vld=%0b id=%0d pend=%b ovr=%0d",
                         $time, evt_vld, evt_id, pend, ovr_cnt, e.vld, e.id, e.pend, e.ovr);
            end
        end
        if (rst === 1'b0 && evt_vld === 1'b1 && evt_rdy === 1'b1) begin
            n_tests++;
            if (exp_hs_q.size() == 0) begin
                n_fail++;
                $display("FAIL handshake @%0t: got id=%0d, want no handshake", $time, evt_id);
            end else begin
                want = exp_hs_q.pop_front();
                if (evt_id !== ID_W'(want)) begin
                    n_fail++;
                    $display("FAIL handshake @%0t: got id=%0d, want id=%0d", $time, evt_id, want);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] cur;

        // Reset state
        drive('0, 1'b0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b0, 1'b0);
        check_val("reset_vld", int'(evt_vld), 0);
        check_val("reset_pend", int'(pend), 0);
        check_val("reset_ovr", int'(ovr_cnt), 0);

        // Single press of ch2, consumer always ready: offer appears 3 edges after the press edge
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        check_val("t1_vld_early", int'(evt_vld), 0);
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        check_val("t1_pend2", int'(pend), 4);
        check_val("t1_vld_early2", int'(evt_vld), 0);
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        check_val("t1_vld", int'(evt_vld), 1);
        check_val("t1_id", int'(evt_id), 2);
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        check_val("t1_vld_one_cycle", int'(evt_vld), 0);
        check_val("t1_pend_clear", int'(pend), 0);
        repeat (4) drive('0, 1'b1, 1'b0, 1'b0);
        check_val("t1_ovr", int'(ovr_cnt), 0);

        // All four at once from a fresh pointer, then ch0+ch1 after the pointer wrapped from 3
        drive('0, 1'b0, 1'b0, 1'b1);
        repeat (3) drive(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (12) drive('0, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(4'b0011, 1'b1, 1'b0, 1'b0);
        repeat (8) drive('0, 1'b1, 1'b0, 1'b0);

        // Consumer stalled, ch3 pressed three times: one held offer, two overruns, then clear
        for (int k = 0; k < 3; k++) begin
            repeat (2) drive(4'b1000, 1'b0, 1'b0, 1'b0);
            repeat (2) drive('0, 1'b0, 1'b0, 1'b0);
        end
        repeat (3) drive('0, 1'b0, 1'b0, 1'b0);
        check_val("t3_vld", int'(evt_vld), 1);
        check_val("t3_id", int'(evt_id), 3);
        check_val("t3_ovr", int'(ovr_cnt), 2);
        drive('0, 1'b0, 1'b1, 1'b0);
        check_val("t3_ovr_clr", int'(ovr_cnt), 0);
        repeat (4) drive('0, 1'b1, 1'b0, 1'b0);

        // ch1 rise lands on the same edge as the ch1 handshake: pend stays set, no overrun
        repeat (2) drive(4'b0010, 1'b0, 1'b0, 1'b0);
        repeat (4) drive('0, 1'b0, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        drive(4'b0010, 1'b1, 1'b0, 1'b0);
        check_val("t4_pend1", int'(pend[1]), 1);
        check_val("t4_vld_bubble", int'(evt_vld), 0);
        drive('0, 1'b0, 1'b0, 1'b0);
        check_val("t4_reoffer_vld", int'(evt_vld), 1);
        check_val("t4_reoffer_id", int'(evt_id), 1);
        repeat (4) drive('0, 1'b1, 1'b0, 1'b0);
        check_val("t4_ovr", int'(ovr_cnt), 0);

        // Reset during an offer while ch0 is held: exactly one ch0 event afterwards
        repeat (5) drive(4'b0001, 1'b0, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 1'b0, 1'b1);
        check_val("t5_rst_vld", int'(evt_vld), 0);
        check_val("t5_rst_pend", int'(pend), 0);
        repeat (8) drive(4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (4) drive('0, 1'b1, 1'b0, 1'b0);

        // Saturation: nine drops on ch2 saturate the counter
        for (int k = 0; k < 10; k++) begin
            repeat (2) drive(4'b0100, 1'b0, 1'b0, 1'b0);
            repeat (2) drive('0, 1'b0, 1'b0, 1'b0);
        end
        repeat (2) drive('0, 1'b0, 1'b0, 1'b0);
        check_val("t5_ovr_sat", int'(ovr_cnt), OVR_MAX);
        drive('0, 1'b1, 1'b1, 1'b0);
        repeat (6) drive('0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic
        cur = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) cur[i] = ~cur[i];
            end
            drive(cur, ($urandom_range(9) < 7), ($urandom_range(59) == 0), ($urandom_range(299) == 0));
        end
        repeat (12) drive('0, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        check_val("left_state_exp", exp_st_q.size(), 0);
        check_val("left_handshake_exp", exp_hs_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
